// File: rtl/pc_dispatch_queue_if.sv
// Interface bundling the table-write, enqueue, request and status signals of the
// PC dispatch queue. The master modport is the processor/host side, the slave
// modport is the queue itself.
interface pc_dispatch_queue_if #(
  parameter int unsigned PC_W = 16
) ();

  logic            tbl_wen;
  logic [3:0]      tbl_waddr;
  logic [PC_W-1:0] tbl_wval;
  logic            queue_wen;
  logic [3:0]      queue_number;
  logic            request_new_pc;
  logic [PC_W-1:0] new_pc;
  logic [1:0]      idle;
  logic [4:0]      count;
  logic            overflow;

  modport master (
    output tbl_wen,
    output tbl_waddr,
    output tbl_wval,
    output queue_wen,
    output queue_number,
    output request_new_pc,
    input  new_pc,
    input  idle,
    input  count,
    input  overflow
  );

  modport slave (
    input  tbl_wen,
    input  tbl_waddr,
    input  tbl_wval,
    input  queue_wen,
    input  queue_number,
    input  request_new_pc,
    output new_pc,
    output idle,
    output count,
    output overflow
  );

endinterface

// File: rtl/pc_dispatch_queue.sv
// PC dispatch queue: a 16-entry table of entry-point PCs, a FIFO of table values
// selected by index, and a two-state FSM that hands the next PC to the processor
// on request. Optional macro DISPATCH_BYPASS_EN delivers an enqueue straight to
// new_pc when a request is already waiting on an empty FIFO.
module pc_dispatch_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = 16
) (
  input logic                clk,
  input logic                rst,
  pc_dispatch_queue_if.slave bus
);

  localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DepthCnt = 5'(DEPTH);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e state_q, state_d;

  logic [PC_W-1:0] tbl_q  [16];
  logic [PC_W-1:0] fifo_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;
  logic [PC_W-1:0] new_pc_q, new_pc_d;
  logic [1:0]      idle_q, idle_d;
  logic            overflow_q, overflow_d;

  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            push;
  logic            bypass;
  logic            drop;
  logic [PC_W-1:0] tbl_rd_val;

  assign fifo_empty = (count_q == 5'd0);
  assign fifo_full  = (count_q == DepthCnt);
  // Combinational read gives the pre-write value on a same-cycle table write.
  assign tbl_rd_val = tbl_q[bus.queue_number];

  // Decode pop and bypass events from the current state and inputs.
  always_comb begin
    pop    = 1'b0;
    bypass = 1'b0;
    unique case (state_q)
      StIdle: pop = bus.request_new_pc && !fifo_empty;
      StWait: begin
        pop = !fifo_empty;
`ifdef DISPATCH_BYPASS_EN
        bypass = fifo_empty && bus.queue_wen;
`else
        bypass = 1'b0;
`endif
      end
      default: begin
        pop    = 1'b0;
        bypass = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a request in StWait is ignored so requests never stack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.request_new_pc && fifo_empty) state_d = StWait;
      StWait: if (pop || bypass) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: next values of the registered new_pc and idle outputs.
  always_comb begin
    new_pc_d = new_pc_q;
    if (pop) begin
      new_pc_d = fifo_q[rd_ptr_q];
    end else if (bypass) begin
      new_pc_d = tbl_rd_val;
    end
    idle_d = (state_d == StWait) ? 2'd1 : 2'd0;
  end

  // FIFO bookkeeping: a full FIFO still accepts a push when it pops in the same cycle.
  always_comb begin
    push       = bus.queue_wen && !bypass && (!fifo_full || pop);
    drop       = bus.queue_wen && !bypass && fifo_full && !pop;
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    overflow_d = overflow_q || drop;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + 5'd1;
    end else if (pop && !push) begin
      count_d = count_q - 5'd1;
    end
  end

  // Entry-point table; cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (bus.tbl_wen) begin
      tbl_q[bus.tbl_waddr] <= bus.tbl_wval;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_q[wr_ptr_q] <= tbl_rd_val;
    end
  end

  // Pointer, occupancy and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      new_pc_q   <= '0;
      idle_q     <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      new_pc_q   <= new_pc_d;
      idle_q     <= idle_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.new_pc   = new_pc_q;
  assign bus.idle     = idle_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_pc_dispatch_queue.sv
// Directed self-checking bench for pc_dispatch_queue (DEPTH=8, PC_W=16).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_pc_dispatch_queue;

  localparam int unsigned Depth = 8;
  localparam int unsigned PcW   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fails  = 0;

  pc_dispatch_queue_if #(.PC_W(PcW)) bus ();

  pc_dispatch_queue #(
    .DEPTH(Depth),
    .PC_W (PcW)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.tbl_wen        = 1'b0;
    bus.tbl_waddr      = 4'd0;
    bus.tbl_wval       = '0;
    bus.queue_wen      = 1'b0;
    bus.queue_number   = 4'd0;
    bus.request_new_pc = 1'b0;
  endtask

  task automatic tbl_write(input logic [3:0] idx, input logic [15:0] val);
    bus.tbl_wen   = 1'b1;
    bus.tbl_waddr = idx;
    bus.tbl_wval  = val;
    tick();
    bus.tbl_wen   = 1'b0;
  endtask

  task automatic enqueue(input logic [3:0] idx);
    bus.queue_wen    = 1'b1;
    bus.queue_number = idx;
    tick();
    bus.queue_wen    = 1'b0;
  endtask

  task automatic request();
    bus.request_new_pc = 1'b1;
    tick();
    bus.request_new_pc = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_new_pc", 32'(bus.new_pc), 32'h0);
    check_eq("rst_idle", 32'(bus.idle), 32'd0);
    check_eq("rst_count", 32'(bus.count), 32'd0);
    check_eq("rst_overflow", 32'(bus.overflow), 32'd0);

    // Basic delivery
    tbl_write(4'd3, 16'h0040);
    enqueue(4'd3);
    check_eq("basic_count_1", 32'(bus.count), 32'd1);
    request();
    check_eq("basic_new_pc", 32'(bus.new_pc), 32'h0040);
    check_eq("basic_idle", 32'(bus.idle), 32'd0);
    check_eq("basic_count_0", 32'(bus.count), 32'd0);

    // Ordering
    tbl_write(4'd1, 16'h0010);
    tbl_write(4'd2, 16'h0020);
    tbl_write(4'd5, 16'h0050);
    enqueue(4'd1);
    enqueue(4'd2);
    enqueue(4'd5);
    check_eq("order_count", 32'(bus.count), 32'd3);
    request();
    check_eq("order_pc0", 32'(bus.new_pc), 32'h0010);
    tick();
    check_eq("order_hold", 32'(bus.new_pc), 32'h0010);
    request();
    check_eq("order_pc1", 32'(bus.new_pc), 32'h0020);
    request();
    check_eq("order_pc2", 32'(bus.new_pc), 32'h0050);
    check_eq("order_count_0", 32'(bus.count), 32'd0);

    // Wait path
    tbl_write(4'd9, 16'h0123);
    request();
    check_eq("wait_idle_1", 32'(bus.idle), 32'd1);
    request();
    check_eq("wait_req_ignored", 32'(bus.idle), 32'd1);
    enqueue(4'd9);
`ifdef DISPATCH_BYPASS_EN
    check_eq("wait_bypass_pc", 32'(bus.new_pc), 32'h0123);
    check_eq("wait_bypass_idle", 32'(bus.idle), 32'd0);
    check_eq("wait_bypass_count", 32'(bus.count), 32'd0);
`else
    check_eq("wait_push_count", 32'(bus.count), 32'd1);
    check_eq("wait_push_idle", 32'(bus.idle), 32'd1);
    tick();
    check_eq("wait_pop_pc", 32'(bus.new_pc), 32'h0123);
    check_eq("wait_pop_idle", 32'(bus.idle), 32'd0);
    check_eq("wait_pop_count", 32'(bus.count), 32'd0);
`endif
    tick();
    check_eq("wait_no_stack", 32'(bus.idle), 32'd0);

    // Overflow: DEPTH+1 enqueues with no pops
    for (int i = 0; i <= int'(Depth); i++) begin
      tbl_write(4'(i), 16'(16'h0100 + i));
    end
    for (int i = 0; i <= int'(Depth); i++) begin
      enqueue(4'(i));
    end
    check_eq("ovf_count", 32'(bus.count), 32'(Depth));
    check_eq("ovf_flag", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < int'(Depth); i++) begin
      request();
      check_eq($sformatf("ovf_drain%0d", i), 32'(bus.new_pc), 32'(16'h0100 + i));
    end
    check_eq("ovf_drained", 32'(bus.count), 32'd0);
    request();
    check_eq("ovf_last_dropped", 32'(bus.idle), 32'd1);
    check_eq("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Reset with queued entries; inputs held active during reset are ignored
    reset_pulse();
    for (int i = 1; i <= 3; i++) begin
      tbl_write(4'(i), 16'(16'h0A00 + i));
    end
    enqueue(4'd1);
    enqueue(4'd2);
    enqueue(4'd3);
    request();
    check_eq("rst2_pre_pc", 32'(bus.new_pc), 32'h0A01);
    enqueue(4'd1);
    check_eq("rst2_pre_count", 32'(bus.count), 32'd3);
    rst                = 1'b1;
    bus.queue_wen      = 1'b1;
    bus.queue_number   = 4'd1;
    bus.request_new_pc = 1'b1;
    bus.tbl_wen        = 1'b1;
    bus.tbl_waddr      = 4'd4;
    bus.tbl_wval       = 16'hBEEF;
    tick();
    rst = 1'b0;
    idle_inputs();
    check_eq("rst2_count", 32'(bus.count), 32'd0);
    check_eq("rst2_idle", 32'(bus.idle), 32'd0);
    check_eq("rst2_new_pc", 32'(bus.new_pc), 32'h0);
    check_eq("rst2_overflow", 32'(bus.overflow), 32'd0);
    request();
    check_eq("rst2_req_idle", 32'(bus.idle), 32'd1);
    // Reset while a request is pending discards it
    reset_pulse();
    check_eq("rst3_idle", 32'(bus.idle), 32'd0);
    enqueue(4'd4);
    check_eq("rst3_count", 32'(bus.count), 32'd1);
    check_eq("rst3_still_idle", 32'(bus.idle), 32'd0);
    request();
    check_eq("rst3_tbl_cleared", 32'(bus.new_pc), 32'h0);

    // Boundary: full FIFO with simultaneous enqueue and request
    reset_pulse();
    for (int i = 0; i < int'(Depth); i++) begin
      tbl_write(4'(i), 16'(16'h0200 + i));
    end
    for (int i = 0; i < int'(Depth); i++) begin
      enqueue(4'(i));
    end
    check_eq("full_count", 32'(bus.count), 32'(Depth));
    bus.queue_wen      = 1'b1;
    bus.queue_number   = 4'd1;
    bus.request_new_pc = 1'b1;
    tick();
    idle_inputs();
    check_eq("full_pushpop_pc", 32'(bus.new_pc), 32'h0200);
    check_eq("full_pushpop_count", 32'(bus.count), 32'(Depth));
    check_eq("full_pushpop_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 1; i < int'(Depth); i++) begin
      request();
      check_eq($sformatf("full_drain%0d", i), 32'(bus.new_pc), 32'(16'h0200 + i));
    end
    request();
    check_eq("full_drain_tail", 32'(bus.new_pc), 32'h0201);
    check_eq("full_drain_count", 32'(bus.count), 32'd0);

    // Boundary: table write and enqueue of the same index in one cycle
    bus.tbl_wen      = 1'b1;
    bus.tbl_waddr    = 4'd7;
    bus.tbl_wval     = 16'h0777;
    bus.queue_wen    = 1'b1;
    bus.queue_number = 4'd7;
    tick();
    idle_inputs();
    request();
    check_eq("same_idx_old", 32'(bus.new_pc), 32'h0207);
    enqueue(4'd7);
    request();
    check_eq("same_idx_new", 32'(bus.new_pc), 32'h0777);
    check_eq("final_ovf", 32'(bus.overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
